// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: inst and data masters share one memory port, returns routed in order.
// Define SRAM_ARB_RR_EN for round-robin selection between simultaneous requesters; default is data-over-inst.
module sram_like_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic             lock_v_q, lock_v_d;
   logic             lock_own_q, lock_own_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] fifo_q;

   logic full, empty;
   logic sel_v, sel_own, sel_req;
   logic accept, ret_fifo, bypass, push, pop;
   logic ret_v, ret_own, head_own;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

`ifdef SRAM_ARB_RR_EN
   logic last_own_q, last_own_d;

   // With both sides requesting, the side that did not win last time goes first.
   always_comb begin
      sel_v   = 1'b0;
      sel_own = 1'b0;
      if (lock_v_q) begin
         sel_v   = 1'b1;
         sel_own = lock_own_q;
      end else begin
         sel_v   = data_req | inst_req;
         sel_own = data_req & ~(inst_req & last_own_q);
      end
   end

   assign last_own_d = accept ? sel_own : last_own_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_own_q <= 1'b0;
      end else begin
         last_own_q <= last_own_d;
      end
   end
`else
   always_comb begin
      sel_v   = 1'b0;
      sel_own = 1'b0;
      if (lock_v_q) begin
         sel_v   = 1'b1;
         sel_own = lock_own_q;
      end else begin
         sel_v   = data_req | inst_req;
         sel_own = data_req;
      end
   end
`endif

   assign sel_req = sel_own ? data_req : inst_req;

   assign mem_req   = ~full & sel_v & sel_req;
   assign mem_wr    = sel_v ? (sel_own ? data_wr    : inst_wr)    : 1'b0;
   assign mem_size  = sel_v ? (sel_own ? data_size  : inst_size)  : 2'b00;
   assign mem_addr  = sel_v ? (sel_own ? data_addr  : inst_addr)  : 32'h0;
   assign mem_wdata = sel_v ? (sel_own ? data_wdata : inst_wdata) : 32'h0;

   assign accept       = mem_req & mem_addr_ok;
   assign inst_addr_ok = accept & ~sel_own;
   assign data_addr_ok = accept & sel_own;

   // An empty FIFO with a simultaneous accept means the return belongs to that accept.
   assign head_own = fifo_q[rd_ptr_q];
   assign ret_fifo = mem_data_ok & ~empty;
   assign bypass   = mem_data_ok & empty & accept;
   assign pop      = ret_fifo;
   assign push     = accept & ~bypass;
   assign ret_v    = ret_fifo | bypass;
   assign ret_own  = ret_fifo ? head_own : sel_own;

   assign inst_data_ok = ret_v & ~ret_own;
   assign data_data_ok = ret_v & ret_own;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Once presented without acceptance the owner is frozen until it is taken.
   always_comb begin
      lock_v_d   = lock_v_q;
      lock_own_d = lock_own_q;
      if (accept) begin
         lock_v_d = 1'b0;
      end else if (mem_req) begin
         lock_v_d   = 1'b1;
         lock_own_d = sel_own;
      end
   end

   always_comb begin
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_v_q   <= 1'b0;
         lock_own_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         fifo_q     <= '0;
      end else begin
         lock_v_q   <= lock_v_d;
         lock_own_q <= lock_own_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= sel_own;
         end
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized plus directed bench for sram_like_arbiter against a queue-based reference model.
module tb_sram_like_arbiter;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_addr_ok, mem_data_ok;

   always #5 clk = ~clk;

   sram_like_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: owner queue in acceptance order plus the address-phase lock.
   bit          q[$];
   bit          m_lock, m_lown, m_last;
   logic        e_mreq, e_wr;
   logic [1:0]  e_size;
   logic [31:0] e_addr, e_wdata;
   logic        e_iaok, e_daok, e_idok, e_ddok;
   bit          e_own, e_accept, e_push, e_pop;

   function automatic void model_reset();
      q.delete();
      m_lock = 1'b0; m_lown = 1'b0; m_last = 1'b0;
      e_iaok = 1'b0; e_daok = 1'b0; e_idok = 1'b0; e_ddok = 1'b0;
      e_accept = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_mreq = 1'b0;
   endfunction

   function automatic void model_eval();
      bit sel, is_full, own, want;
      is_full = (q.size() == DEPTH);
      if (m_lock) begin
         sel = 1'b1;
         own = m_lown;
      end else begin
         sel = inst_req | data_req;
`ifdef SRAM_ARB_RR_EN
         if (inst_req && data_req) own = !m_last;
         else own = data_req;
`else
         own = data_req;
`endif
      end
      want    = own ? data_req : inst_req;
      e_own   = own;
      e_mreq  = sel && want && !is_full;
      e_wr    = sel ? (own ? data_wr : inst_wr) : 1'b0;
      e_size  = sel ? (own ? data_size : inst_size) : 2'b00;
      e_addr  = sel ? (own ? data_addr : inst_addr) : 32'h0;
      e_wdata = sel ? (own ? data_wdata : inst_wdata) : 32'h0;
      e_accept = e_mreq && mem_addr_ok;
      e_iaok  = e_accept && !own;
      e_daok  = e_accept && own;
      e_idok  = 1'b0; e_ddok = 1'b0; e_pop = 1'b0; e_push = e_accept;
      if (mem_data_ok) begin
         if (q.size() > 0) begin
            e_pop = 1'b1;
            if (q[0]) e_ddok = 1'b1; else e_idok = 1'b1;
         end else if (e_accept) begin
            e_push = 1'b0;
            if (own) e_ddok = 1'b1; else e_idok = 1'b1;
         end
      end
   endfunction

   function automatic void model_update();
      if (rst) begin
         model_reset();
      end else begin
         if (e_pop) void'(q.pop_front());
         if (e_push) q.push_back(e_own);
         if (e_accept) begin
            m_lock = 1'b0;
            m_last = e_own;
         end else if (e_mreq) begin
            m_lock = 1'b1;
            m_lown = e_own;
         end
      end
   endfunction

   // Called just after a rising edge with inputs already set; returns just after the next edge.
   task automatic step();
      @(negedge clk);
      model_eval();
      check_val("mem_req", 32'(mem_req), 32'(e_mreq));
      check_val("mem_wr", 32'(mem_wr), 32'(e_wr));
      check_val("mem_size", 32'(mem_size), 32'(e_size));
      check_val("mem_addr", mem_addr, e_addr);
      check_val("mem_wdata", mem_wdata, e_wdata);
      check_val("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
      check_val("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
      check_val("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
      check_val("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
      check_val("inst_rdata", inst_rdata, mem_rdata);
      check_val("data_rdata", data_rdata, mem_rdata);
      if (e_accept)
         $display("t=%0t accept %s addr=0x%08h wr=%0d", $time, e_own ? "data" : "inst", e_addr, e_wr);
      if (e_idok || e_ddok)
         $display("t=%0t return %s rdata=0x%08h", $time, e_ddok ? "data" : "inst", mem_rdata);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b00; inst_addr = 32'h0; inst_wdata = 32'h0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = 32'h0; data_wdata = 32'h0;
      mem_rdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("rst_mem_req", 32'(mem_req), 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      check_val("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_random();
      if (!inst_req || e_iaok) begin
         inst_req   = ($urandom_range(0, 2) != 0);
         inst_wr    = 1'($urandom_range(0, 1));
         inst_size  = 2'($urandom_range(0, 3));
         inst_addr  = $urandom;
         inst_wdata = $urandom;
      end
      if (!data_req || e_daok) begin
         data_req   = ($urandom_range(0, 2) != 0);
         data_wr    = 1'($urandom_range(0, 1));
         data_size  = 2'($urandom_range(0, 3));
         data_addr  = $urandom;
         data_wdata = $urandom;
      end
      mem_addr_ok = 1'($urandom_range(0, 1));
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata   = $urandom;
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      model_reset();
      do_reset();

      // Single data read with a return one cycle later.
      data_req = 1'b1; data_addr = 32'h100; data_size = 2'd2; mem_addr_ok = 1'b1;
      #1;
      check_val("t1_data_addr_ok", 32'(data_addr_ok), 32'd1);
      check_val("t1_mem_addr", mem_addr, 32'h100);
      step();
      data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
      #1;
      check_val("t1_data_data_ok", 32'(data_data_ok), 32'd1);
      check_val("t1_data_rdata", data_rdata, 32'hDEADBEEF);
      check_val("t1_inst_data_ok", 32'(inst_data_ok), 32'd0);
      step();
      set_idle();

      // Both sides request continuously until the FIFO fills.
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_addr = 32'h20; mem_addr_ok = 1'b1;
      #1;
      check_val("t2_first_data", 32'(data_addr_ok), 32'd1);
      step();
      #1;
`ifdef SRAM_ARB_RR_EN
      check_val("t2_second_inst", 32'(inst_addr_ok), 32'd1);
`else
      check_val("t2_second_data", 32'(data_addr_ok), 32'd1);
`endif
      step();
      #1;
      check_val("t2_full_blocks", 32'(mem_req), 32'd0);
      step();
      set_idle();

      // Address phase stays with inst while stalled, data follows.
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h200;
      #1;
      check_val("t3_c1_addr", mem_addr, 32'h200);
      step();
      data_req = 1'b1; data_addr = 32'h300;
      #1;
      check_val("t3_c2_addr", mem_addr, 32'h200);
      step();
      #1;
      check_val("t3_c3_addr", mem_addr, 32'h200);
      step();
      mem_addr_ok = 1'b1;
      #1;
      check_val("t3_inst_acc", 32'(inst_addr_ok), 32'd1);
      step();
      inst_req = 1'b0;
      #1;
      check_val("t3_data_acc", 32'(data_addr_ok), 32'd1);
      check_val("t3_data_addr", mem_addr, 32'h300);
      step();
      set_idle();

      // In-order return routing, then a spurious return once drained.
      do_reset();
      inst_req = 1'b1; mem_addr_ok = 1'b1;
      step();
      inst_req = 1'b0; data_req = 1'b1;
      step();
      data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
      #1;
      check_val("t4_ret1_inst", 32'(inst_data_ok), 32'd1);
      check_val("t4_ret1_data", 32'(data_data_ok), 32'd0);
      step();
      mem_rdata = 32'h22222222;
      #1;
      check_val("t4_ret2_data", 32'(data_data_ok), 32'd1);
      check_val("t4_ret2_inst", 32'(inst_data_ok), 32'd0);
      step();
      #1;
      check_val("t4_drained", 32'({inst_data_ok, data_data_ok}), 32'd0);
      step();
      set_idle();

      // Spurious return, then same-cycle accept and return.
      do_reset();
      mem_data_ok = 1'b1;
      #1;
      check_val("t5_spurious", 32'({inst_data_ok, data_data_ok}), 32'd0);
      step();
      data_req = 1'b1; mem_addr_ok = 1'b1;
      #1;
      check_val("t5_bypass_aok", 32'(data_addr_ok), 32'd1);
      check_val("t5_bypass_dok", 32'(data_data_ok), 32'd1);
      step();
      data_req = 1'b0; mem_addr_ok = 1'b0;
      #1;
      check_val("t5_no_push", 32'(data_data_ok), 32'd0);
      step();
      set_idle();

      // Asynchronous reset with the FIFO full.
      do_reset();
      data_req = 1'b1; mem_addr_ok = 1'b1;
      step();
      step();
      mem_addr_ok = 1'b0;
      #1;
      check_val("t6_full", 32'(mem_req), 32'd0);
      rst = 1'b1;
      model_reset();
      #1;
      check_val("t6_async_clear", 32'(mem_req), 32'd1);
      step();
      rst = 1'b0;
      data_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE0001;
      #1;
      check_val("t6_dropped", 32'({inst_data_ok, data_data_ok}), 32'd0);
      step();
      set_idle();

      do_reset();
      repeat (2000) begin
         drive_random();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
